// File: rtl/mandel_pkg.sv
// mandel_pkg
// Shared definitions for the mandelbrot pixel scheduler:
//   ITER_W_DEF / PIX_W_DEF : default iteration-count and coordinate widths
//   sched_state_e          : scheduler frame FSM states
//   seq_width()            : width of a raster sequence counter for a WxH frame
package mandel_pkg;

    localparam int ITER_W_DEF = 32;
    localparam int PIX_W_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // The counter has to hold W*H itself: that value is the "frame done" marker.
    function automatic int seq_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin pick of the lowest requesting index at or after ptr (wrapping).
// Ports:
//   req       in  N    request vector
//   ptr       in  IW   search start index, must be < N
//   grant     out N    one-hot grant (all zero when nothing requests)
//   grant_idx out IW   binary index of the grant
//   any       out 1    some request was granted
module rr_arbiter
    import mandel_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    function automatic int wrap(input int a);
        return a % N;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap(int'(ptr) + k)]) begin
                any                         = 1'b1;
                grant[wrap(int'(ptr) + k)]  = 1'b1;
                grant_idx                   = IW'(wrap(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler
// Hands raster-ordered pixel jobs to any idle engine (round-robin, one per cycle),
// tags each job with its raster slot in a reorder buffer, collects results in any
// order and streams them out strictly in raster order with valid/ready.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start / busy               frame start pulse (IDLE only) / frame in progress
//   eng_ready                  per-engine idle indication
//   eng_start, eng_x, eng_y    per-engine job pulse and held coordinates
//   eng_done, eng_iter         per-engine result pulse and iteration count
//   out_valid/out_ready/out_iter  raster-ordered result stream
//   out_first/out_last_x/out_last_y  position flags qualified by out_valid
//   proto_err                  sticky: result from an engine that had no job
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 12,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int ROB_DEPTH   = 32,
    parameter int ITER_W      = ITER_W_DEF,
    parameter int PIX_W       = PIX_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    input  logic [NUM_ENGINES-1:0]        eng_ready,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [NUM_ENGINES*PIX_W-1:0]  eng_x,
    output logic [NUM_ENGINES*PIX_W-1:0]  eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_iter,
    output logic                          out_first,
    output logic                          out_last_x,
    output logic                          out_last_y,
    output logic                          proto_err
);

    localparam int TOTAL  = SCREEN_W * SCREEN_H;
    localparam int SEQ_W  = seq_width(SCREEN_W, SCREEN_H);
    localparam int ROB_AW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int IDX_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    localparam logic [SEQ_W-1:0] SEQ_END = SEQ_W'(TOTAL);
    localparam logic [PIX_W-1:0] X_LAST  = PIX_W'(SCREEN_W - 1);
    localparam logic [PIX_W-1:0] Y_LAST  = PIX_W'(SCREEN_H - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_ENGINES - 1);

    sched_state_e state_q, state_d;

    logic [SEQ_W-1:0] issue_seq, retire_seq;
    logic [PIX_W-1:0] issue_x, issue_y, ret_x, ret_y;

    logic [NUM_ENGINES-1:0]             busy_q, req, grant, done_ok;
    logic [NUM_ENGINES-1:0][ROB_AW-1:0] tag_q;
    logic [NUM_ENGINES-1:0][PIX_W-1:0]  ex_q, ey_q;
    logic [NUM_ENGINES-1:0][ITER_W-1:0] iter_a;

    logic [ROB_DEPTH-1:0][ITER_W-1:0]   rob;
    logic [ROB_DEPTH-1:0]               rob_vld;

    logic [IDX_W-1:0]  rr_ptr, grant_idx;
    logic              any_grant, issue_en, rob_room, retire_fire, frame_end;
    logic [ROB_AW-1:0] issue_tag, head;
    logic [31:0]       occupancy;

    assign iter_a = eng_iter;
    assign eng_x  = ex_q;
    assign eng_y  = ey_q;
    assign busy   = (state_q != IDLE);

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                  state_d = RUN;
            RUN:     if (issue_seq == SEQ_END)   state_d = DRAIN;
            DRAIN:   if (retire_seq == SEQ_END)  state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    assign frame_end = (state_q == DRAIN) && (state_d == IDLE);

    // ---------------------------------------------------------------- issue
    // Counters sit at zero in IDLE, so the start cycle itself may issue pixel
    // (0,0); that puts the first eng_start in the cycle right after start.
    assign occupancy = 32'(issue_seq) - 32'(retire_seq);
    assign rob_room  = occupancy < 32'(ROB_DEPTH);
    assign issue_en  = ((state_q == RUN) || (state_q == IDLE && start))
                       && (issue_seq != SEQ_END) && rob_room;
    assign issue_tag = ROB_AW'(32'(issue_seq) % ROB_DEPTH);
    assign req       = eng_ready & ~busy_q & {NUM_ENGINES{issue_en}};
    assign done_ok   = eng_done & busy_q;

    rr_arbiter #(.N(NUM_ENGINES)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_grant)
    );

    // --------------------------------------------------------------- retire
    assign head        = ROB_AW'(32'(retire_seq) % ROB_DEPTH);
    assign out_valid   = rob_vld[head];
    assign out_iter    = out_valid ? rob[head] : '0;
    assign retire_fire = out_valid && out_ready;
    assign out_first   = out_valid && (ret_x == '0) && (ret_y == '0);
    assign out_last_x  = out_valid && (ret_x == X_LAST);
    assign out_last_y  = out_valid && (ret_x == X_LAST) && (ret_y == Y_LAST);

    // Result storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++)
            if (done_ok[i]) rob[tag_q[i]] <= iter_a[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            issue_seq  <= '0;
            retire_seq <= '0;
            issue_x    <= '0;
            issue_y    <= '0;
            ret_x      <= '0;
            ret_y      <= '0;
            busy_q     <= '0;
            tag_q      <= '0;
            ex_q       <= '0;
            ey_q       <= '0;
            rob_vld    <= '0;
            rr_ptr     <= '0;
            eng_start  <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            eng_start <= grant;
            busy_q    <= (busy_q & ~done_ok) | grant;

            if (any_grant) begin
                rr_ptr    <= (grant_idx == IDX_MAX) ? '0 : grant_idx + 1'b1;
                issue_seq <= issue_seq + 1'b1;
                if (issue_x == X_LAST) begin
                    issue_x <= '0;
                    issue_y <= issue_y + 1'b1;
                end else begin
                    issue_x <= issue_x + 1'b1;
                end
            end

            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (grant[i]) begin
                    ex_q[i]  <= issue_x;
                    ey_q[i]  <= issue_y;
                    tag_q[i] <= issue_tag;
                end
            end

            // A slot being retired can't be rewritten this cycle: the only job
            // that maps to it is ROB_DEPTH sequence numbers ahead, which the
            // occupancy limit keeps from issuing until this retire is done.
            if (retire_fire) begin
                rob_vld[head] <= 1'b0;
                retire_seq    <= retire_seq + 1'b1;
                if (ret_x == X_LAST) begin
                    ret_x <= '0;
                    ret_y <= ret_y + 1'b1;
                end else begin
                    ret_x <= ret_x + 1'b1;
                end
            end

            for (int i = 0; i < NUM_ENGINES; i++)
                if (done_ok[i]) rob_vld[tag_q[i]] <= 1'b1;

            if (|(eng_done & ~busy_q)) proto_err <= 1'b1;

            // Rewind the counters so the next start can issue immediately.
            if (frame_end) begin
                issue_seq  <= '0;
                retire_seq <= '0;
                issue_x    <= '0;
                issue_y    <= '0;
                ret_x      <= '0;
                ret_y      <= '0;
            end
        end
    end

endmodule
